// File: rtl/infrared_rcv.sv
// NEC infrared remote decoder: measures low/high durations on the synchronised
// IR line, validates leader and 32 data bits, publishes the command byte and flags repeat frames.
//
// state  | meaning
// IDLE   | line idle, waiting for the leader burst to start
// LEAD_L | inside the 9 ms leader burst
// LEAD_H | inside the space after the leader (frame or repeat)
// BIT_L  | inside the 560 us low mark that starts each data bit
// BIT_H  | inside the high space that encodes the bit value
// REP    | inside the stop burst of a repeat frame, repeat_en high
module infrared_rcv #(
  parameter int unsigned CNT_US = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       infrared_in,
  output logic       repeat_en,
  output logic [7:0] data
);

  localparam logic [19:0] T_TO      = 20'(10000 * CNT_US);
  localparam logic [19:0] LEAD_MIN  = 20'(8000 * CNT_US);
  localparam logic [19:0] LEAD_MAX  = 20'(10000 * CNT_US);
  localparam logic [19:0] SPACE_MIN = 20'(4000 * CNT_US);
  localparam logic [19:0] SPACE_MAX = 20'(5000 * CNT_US);
  localparam logic [19:0] REP_MIN   = 20'(2000 * CNT_US);
  localparam logic [19:0] REP_MAX   = 20'(2500 * CNT_US);
  localparam logic [19:0] SHORT_MIN = 20'(400 * CNT_US);
  localparam logic [19:0] SHORT_MAX = 20'(700 * CNT_US);
  localparam logic [19:0] ONE_MIN   = 20'(1500 * CNT_US);
  localparam logic [19:0] ONE_MAX   = 20'(1900 * CNT_US);

  typedef enum logic [2:0] {IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, REP} state_t;

  state_t      state_q, state_d;
  logic        sync_q1, sync_q2;
  logic        fall, rise;
  logic [19:0] cnt;
  logic        timeout;
  logic        in_lead, in_space, in_rep, in_short, in_one;
  logic [31:0] shift_q, shift_d, shift_in;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  data_d;
  logic        rep_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= infrared_in;
      sync_q2 <= sync_q1;
    end
  end

  assign fall = sync_q2 & ~sync_q1;
  assign rise = ~sync_q2 & sync_q1;

  // Duration of the current level; at an edge it still holds the value of the level just ended.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (fall || rise) begin
      cnt <= '0;
    end else if (cnt != T_TO) begin
      cnt <= cnt + 20'd1;
    end
  end

  assign timeout  = (cnt == T_TO);
  assign in_lead  = (cnt >= LEAD_MIN)  && (cnt <= LEAD_MAX);
  assign in_space = (cnt >= SPACE_MIN) && (cnt <= SPACE_MAX);
  assign in_rep   = (cnt >= REP_MIN)   && (cnt <= REP_MAX);
  assign in_short = (cnt >= SHORT_MIN) && (cnt <= SHORT_MAX);
  assign in_one   = (cnt >= ONE_MIN)   && (cnt <= ONE_MAX);

  // LSB first: after 32 shifts the first received bit lands in bit 0.
  assign shift_in = {in_one, shift_q[31:1]};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    data_d  = data;
    rep_d   = repeat_en;

    case (state_q)
      IDLE: begin
        if (fall) state_d = LEAD_L;
      end
      LEAD_L: begin
        if (rise) state_d = in_lead ? LEAD_H : IDLE;
      end
      LEAD_H: begin
        if (fall) begin
          if (in_space) begin
            state_d = BIT_L;
            idx_d   = '0;
            shift_d = '0;
          end else if (in_rep) begin
            state_d = REP;
            rep_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BIT_L: begin
        if (rise) state_d = in_short ? BIT_H : IDLE;
      end
      BIT_H: begin
        if (fall) begin
          if (in_short || in_one) begin
            shift_d = shift_in;
            if (idx_q == 6'd31) begin
              state_d = IDLE;
              // Only the command pair is checked so extended-address remotes still decode.
              if (shift_in[31:24] == ~shift_in[23:16]) data_d = shift_in[23:16];
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = BIT_L;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      REP: begin
        if (rise) begin
          rep_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge coinciding with the saturated count wins over the timeout.
    if ((state_q != IDLE) && !fall && !rise && timeout) begin
      state_d = IDLE;
      rep_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      data      <= 8'h00;
      repeat_en <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      data      <= data_d;
      repeat_en <= rep_d;
    end
  end

endmodule

// File: tb/tb_infrared_rcv.sv
// Scoreboard bench for infrared_rcv: stimulus pushes expected output events,
// a monitor pops and checks them (value and latency) whenever an output changes.
module tb_infrared_rcv;

  localparam int unsigned CNT_US = 1;
  localparam int EV_DATA = 0;
  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       infrared_in = 1'b1;
  logic       repeat_en;
  logic [7:0] data;

  always #5 sys_clk = ~sys_clk;

  infrared_rcv #(.CNT_US(CNT_US)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .infrared_in(infrared_in),
    .repeat_en  (repeat_en),
    .data       (data)
  );

  typedef struct {
    int         kind;
    logic [7:0] val;
    longint     edge_cyc;
  } ev_t;

  ev_t        exp_q[$];
  longint     cyc = 0;
  int         n_cmp = 0;
  int         n_mis = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_data;
  logic       prev_rep;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic expect_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val = val;
    e.edge_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input logic [7:0] val);
    ev_t    e;
    longint lat;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL unexpected_event: got kind=%0d val=%h at cycle %0d, required no output change",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      lat = cyc - e.edge_cyc;
      if (e.kind != kind || e.val !== val || lat < 0 || lat > 3) begin
        n_mis++;
        $display("FAIL event: got kind=%0d val=%h latency=%0d, required kind=%0d val=%h latency 0..3",
                 kind, val, lat, e.kind, e.val);
      end
    end
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (mon_en) begin
      if (data !== prev_data) got_ev(EV_DATA, data);
      if (repeat_en !== prev_rep) got_ev(repeat_en ? EV_RISE : EV_FALL, 8'h00);
    end
    prev_data = data;
    prev_rep  = repeat_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    infrared_in = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  // Sends leader and the first nbits bits; a full frame also gets its stop burst.
  task automatic send_frame(input logic [31:0] bits, input int nbits,
                            input int ll, input int lh, input int bl,
                            input int b0, input int b1, input int stop,
                            input bit upd, input logic [7:0] val);
    hold(1'b0, ll);
    hold(1'b1, lh);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, bl);
      hold(1'b1, bits[i] ? b1 : b0);
    end
    if (nbits == 32) begin
      if (upd) expect_ev(EV_DATA, val);
      hold(1'b0, stop);
      infrared_in = 1'b1;
    end
  endtask

  task automatic send_repeat(input string name);
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    expect_ev(EV_RISE, 8'h00);
    hold(1'b0, 280);
    check({name, "_mid_pulse"}, {31'd0, repeat_en}, 32'd1);
    hold(1'b0, 280);
    expect_ev(EV_FALL, 8'h00);
    hold(1'b1, 100);
    check({name, "_after_pulse"}, {31'd0, repeat_en}, 32'd0);
  endtask

  task automatic check_drained(input string name);
    check({name, "_pending_events"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  localparam logic [31:0] FRAME_16  = {8'hE9, 8'h16, 8'hFF, 8'h00};
  localparam logic [31:0] FRAME_BAD = {8'h00, 8'h22, 8'hFF, 8'h00};
  localparam logic [31:0] FRAME_45  = {8'hBA, 8'h45, 8'hFF, 8'h00};

  initial begin
    sys_rst_n = 1'b0;
    infrared_in = 1'b1;
    #30 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    mon_en = 1'b1;
    hold(1'b1, 1000);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_repeat", {31'd0, repeat_en}, 32'd0);

    send_frame(FRAME_16, 32, 9000, 4500, 560, 560, 1690, 560, 1'b1, 8'h16);
    hold(1'b1, 2000);
    check("frame16_data", {24'd0, data}, 32'h16);
    check("frame16_repeat", {31'd0, repeat_en}, 32'd0);
    check_drained("frame16");

    hold(1'b1, 15000);
    send_repeat("repeat1");
    hold(1'b1, 5000);
    send_repeat("repeat2");
    hold(1'b1, 2000);
    check("repeat_data_kept", {24'd0, data}, 32'h16);
    check_drained("repeats");

    send_frame(FRAME_BAD, 32, 8100, 4100, 450, 450, 1550, 450, 1'b0, 8'h00);
    hold(1'b1, 2000);
    check("badcomp_data", {24'd0, data}, 32'h16);
    check("badcomp_repeat", {31'd0, repeat_en}, 32'd0);
    check_drained("badcomp");

    hold(1'b0, 5000);
    hold(1'b1, 6000);
    check("short_leader_data", {24'd0, data}, 32'h16);

    send_frame(FRAME_16, 10, 9000, 4500, 560, 560, 1690, 560, 1'b0, 8'h00);
    hold(1'b1, 20000);
    check("timeout_data", {24'd0, data}, 32'h16);
    send_repeat("repeat_after_timeout");
    hold(1'b1, 2000);
    check_drained("timeout");

    send_frame(FRAME_45, 20, 8100, 4100, 450, 450, 1550, 450, 1'b0, 8'h00);
    hold(1'b0, 200);
    expect_ev(EV_DATA, 8'h00);
    sys_rst_n = 1'b0;
    #1;
    check("midreset_data", {24'd0, data}, 32'h00);
    check("midreset_repeat", {31'd0, repeat_en}, 32'd0);
    infrared_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold(1'b1, 3000);

    send_frame(FRAME_45, 32, 8100, 4100, 450, 450, 1550, 450, 1'b1, 8'h45);
    hold(1'b1, 2000);
    check("frame45_data", {24'd0, data}, 32'h45);
    check("frame45_repeat", {31'd0, repeat_en}, 32'd0);
    check_drained("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #20ms;
    n_cmp++;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached, required completion before 20 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

endmodule
